larpix_v3_digital_core: RTL and testbench

- Digital core of a single LArPix-v3 pixel ASIC.
- Receives 64-bit configuration packets over a serial POSI UART and holds them in a register file.
- Handles the external trigger input, gated by a configuration enable bit.
- Queues outbound packets in a FIFO and serializes them on the PISO UART lanes to the FPGA/MCP side.

---
 rtl/larpix_v3_digital_core.sv | 203 ++++++++++++++++++++
 tb/tb_larpix_v3_digital_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/larpix_v3_digital_core.sv
// larpix_v3_digital_core
// Digital core of one LArPix-v3 pixel ASIC.
//   - Serial config RX on the ANDed posi lanes (start 0, 64 data bits LSB
//     first, stop 1, one bit per clk) into a 256 x 8 register file.
//   - External trigger path, gated by reg1[0]. Each accepted trigger emits a
//     one-cycle digital_monitor pulse and queues a timestamped data packet.
//   - Outbound FIFO that serializes onto the piso lanes enabled in reg2[3:0].
// Ports:
//   clk              rising-edge clock
//   reset_n          synchronous active-low reset
//   posi[3:0]        UART RX lanes, idle high, ANDed together
//   external_trigger asynchronous trigger input, active high
//   piso[3:0]        UART TX lanes, idle high
//   digital_monitor  one-cycle pulse per accepted trigger
module larpix_v3_digital_core #(
   parameter int WIDTH      = 64,
   parameter int WORDWIDTH  = 8,
   parameter int REGNUM     = 256,
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_BITS  = 3,
   parameter int TS_BITS    = 24
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] posi,
   input  logic       external_trigger,
   output logic [3:0] piso,
   output logic       digital_monitor
);

   // ---------------- RX ----------------
   logic             rx_s1, rx_s2, rx_prev, rx_busy, pkt_vld;
   logic [6:0]       rx_cnt;
   logic [WIDTH-1:0] rx_shift, pkt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
         rx_busy <= 1'b0; rx_cnt <= '0; rx_shift <= '0;
         pkt_vld <= 1'b0; pkt <= '0;
      end else begin
         rx_s1   <= &posi;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         pkt_vld <= 1'b0;
         if (!rx_busy) begin
            // cycle in which the synchronized line falls is the start bit
            if (rx_prev && !rx_s2) begin
               rx_busy <= 1'b1;
               rx_cnt  <= '0;
            end
         end else if (rx_cnt < 7'(WIDTH)) begin
            rx_shift <= {rx_s2, rx_shift[WIDTH-1:1]};
            rx_cnt   <= rx_cnt + 7'd1;
         end else begin
            rx_busy <= 1'b0;
            if (rx_s2) begin       // stop bit present, else drop the frame
               pkt_vld <= 1'b1;
               pkt     <= rx_shift;
            end
         end
      end
   end

   // ---------------- register file ----------------
   logic [WORDWIDTH-1:0] regs [REGNUM];
   logic                 ovf;
   logic [7:0]           addr, rd_data;
   logic                 pkt_ok, cfg_wr, cfg_rd;

   assign addr    = pkt[17:10];
   assign pkt_ok  = pkt_vld && (^pkt) && (pkt[9:2] == regs[0] || pkt[9:2] == 8'hFF);
   assign cfg_wr  = pkt_ok && (pkt[1:0] == 2'b10);
   assign cfg_rd  = pkt_ok && (pkt[1:0] == 2'b11);
   // reg3 is the read-only overflow flag, never stored in the array
   assign rd_data = (addr == 8'd3) ? {7'b0, ovf} : regs[addr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < REGNUM; i++) regs[i] <= '0;
         regs[0] <= 8'h01;
         regs[2] <= 8'h0F;
      end else if (cfg_wr && addr != 8'd3) begin
         regs[addr] <= pkt[25:18];
      end
   end

   // ---------------- timestamp + trigger ----------------
   logic [TS_BITS-1:0] ts;
   logic               tr_s1, tr_s2, tr_prev, trig_acc;

   assign trig_acc = tr_s2 && !tr_prev && regs[1][0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ts <= '0;
         tr_s1 <= 1'b0; tr_s2 <= 1'b0; tr_prev <= 1'b0;
         digital_monitor <= 1'b0;
      end else begin
         ts      <= ts + TS_BITS'(1);
         tr_s1   <= external_trigger;
         tr_s2   <= tr_s1;
         tr_prev <= tr_s2;
         digital_monitor <= trig_acc;
      end
   end

   // outbound packets; bit 63 makes total parity odd
   logic [62:0]      trig_body, reply_body;
   logic [WIDTH-1:0] trig_pkt, reply_pkt;

   assign trig_body  = {13'b0, 2'b10, 8'b0, ts, 6'h3F, regs[0], 2'b01};
   assign trig_pkt   = {~^trig_body, trig_body};
   assign reply_body = {37'b0, rd_data, addr, regs[0], 2'b11};
   assign reply_pkt  = {~^reply_body, reply_body};

   // ---------------- FIFO write arbitration ----------------
   // Reply wins the single write port; a colliding trigger waits one cycle
   // in the pending slot. A trigger that finds the slot occupied is lost.
   logic             pend_vld, pend_vld_nxt, wr_en, lost;
   logic [WIDTH-1:0] pend_pkt, pend_pkt_nxt, wr_data;

   always_comb begin
      wr_en = 1'b0; wr_data = reply_pkt; lost = 1'b0;
      pend_vld_nxt = pend_vld; pend_pkt_nxt = pend_pkt;
      if (cfg_rd) begin
         wr_en = 1'b1;
         if (trig_acc) begin
            if (pend_vld) lost = 1'b1;
            else begin pend_vld_nxt = 1'b1; pend_pkt_nxt = trig_pkt; end
         end
      end else if (pend_vld) begin
         wr_en = 1'b1; wr_data = pend_pkt; pend_vld_nxt = 1'b0;
         if (trig_acc) begin pend_vld_nxt = 1'b1; pend_pkt_nxt = trig_pkt; end
      end else if (trig_acc) begin
         wr_en = 1'b1; wr_data = trig_pkt;
      end
   end

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [FIFO_BITS:0] wr_ptr, rd_ptr;
   logic             full, empty, pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_BITS] != rd_ptr[FIFO_BITS]) &&
                  (wr_ptr[FIFO_BITS-1:0] == rd_ptr[FIFO_BITS-1:0]);

   always_ff @(posedge clk) begin
      if (wr_en && !full) mem[wr_ptr[FIFO_BITS-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0; rd_ptr <= '0; ovf <= 1'b0;
         pend_vld <= 1'b0; pend_pkt <= '0;
      end else begin
         pend_vld <= pend_vld_nxt;
         pend_pkt <= pend_pkt_nxt;
         if (wr_en && !full) wr_ptr <= wr_ptr + (FIFO_BITS+1)'(1);
         if (pop)            rd_ptr <= rd_ptr + (FIFO_BITS+1)'(1);
         if ((wr_en && full) || lost) ovf <= 1'b1;
      end
   end

   // ---------------- TX ----------------
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   tx_state_t        state, state_nxt;
   logic [6:0]       tx_cnt;      // 0 start, 1..64 data, 65 stop
   logic [WIDTH-1:0] tx_shift;
   logic [3:0]       tx_lanes;    // lane enables latched per frame
   logic             line_bit;

   always_comb begin
      state_nxt = state; pop = 1'b0; line_bit = 1'b1;
      if (state == TX_IDLE) begin
         // the idle cycle doubles as the mandatory gap between frames
         if (!empty) begin pop = 1'b1; state_nxt = TX_SEND; end
      end else begin
         if (tx_cnt == 7'd0)            line_bit = 1'b0;
         else if (tx_cnt <= 7'(WIDTH))  line_bit = tx_shift[0];
         else                           state_nxt = TX_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= TX_IDLE; tx_cnt <= '0; tx_shift <= '0;
         tx_lanes <= '0; piso <= 4'hF;
      end else begin
         state <= state_nxt;
         if (pop) begin
            tx_shift <= mem[rd_ptr[FIFO_BITS-1:0]];
            tx_cnt   <= '0;
            tx_lanes <= regs[2][3:0];
         end else if (state == TX_SEND) begin
            tx_cnt <= tx_cnt + 7'd1;
            if (tx_cnt != 7'd0) tx_shift <= tx_shift >> 1;
         end
         piso <= ~tx_lanes | {4{line_bit}};
      end
   end

endmodule

// File: tb/tb_larpix_v3_digital_core.sv
// Randomized self-checking bench for larpix_v3_digital_core. A register-map
// model predicts config-read replies; a per-lane UART decoder captures every
// frame on piso; trigger packets are checked field by field.
module tb_larpix_v3_digital_core;

   logic       clk, reset_n, external_trigger, digital_monitor;
   logic [3:0] posi, piso;

   larpix_v3_digital_core dut (
      .clk(clk), .reset_n(reset_n), .posi(posi),
      .external_trigger(external_trigger),
      .piso(piso), .digital_monitor(digital_monitor)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0, nerr = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   // ---------------- piso frame capture ----------------
   logic [65:0] capq[$];          // {lane, payload}
   logic [63:0] msh[4];
   int          mcnt[4];
   bit          mbusy[4];
   int          frame_err = 0, lowcnt = 0, last_start = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         for (int l = 0; l < 4; l++) mbusy[l] <= 1'b0;
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (!mbusy[l]) begin
               if (!piso[l]) begin mbusy[l] <= 1'b1; mcnt[l] <= 0; last_start <= cyc; end
            end else if (mcnt[l] < 64) begin
               msh[l][mcnt[l]] <= piso[l];
               mcnt[l] <= mcnt[l] + 1;
            end else begin
               mbusy[l] <= 1'b0;
               if (piso[l]) capq.push_back({2'(l), msh[l]});
               else frame_err <= frame_err + 1;
            end
         end
         if (piso != 4'hF) lowcnt <= lowcnt + 1;
      end
   end

   int dpulse = 0, dhigh = 0;
   logic dprev = 1'b0;
   always @(negedge clk) begin
      dprev <= digital_monitor;
      if (digital_monitor && !dprev) dpulse <= dpulse + 1;
      if (digital_monitor) dhigh <= dhigh + 1;
   end

   // ---------------- reference model ----------------
   logic [7:0] rm[256];
   bit         ovf_m = 1'b0;

   function automatic logic [63:0] mk(input logic [1:0] t, input logic [7:0] c, a, d, input bit bad);
      logic [63:0] p = '0;
      p[1:0] = t; p[9:2] = c; p[17:10] = a; p[25:18] = d;
      p[63] = ($countones(p[62:0]) % 2 == 0);
      if (bad) p[63] = ~p[63];
      return p;
   endfunction

   task automatic send(input logic [63:0] p, input int lane);
      logic [3:0] v;
      @(negedge clk); v = 4'hF; v[lane] = 1'b0; posi = v;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk); v = 4'hF; v[lane] = p[i]; posi = v;
      end
      @(negedge clk); posi = 4'hF;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_frames(input int n, input int budget, input string tag);
      int k = 0;
      while (capq.size() < n && k < budget) begin @(negedge clk); k++; end
      chk(tag, capq.size(), n);
   endtask

   task automatic xact(input logic [1:0] t, input logic [7:0] c, a, d, input bit bad, input int lane);
      bit acc;
      logic [63:0] e;
      logic [65:0] cap;
      send(mk(t, c, a, d, bad), lane);
      acc = !bad && (c == rm[0] || c == 8'hFF);
      if (acc && t == 2'b10 && a != 8'd3) rm[a] = d;
      if (acc && t == 2'b11) begin
         e = mk(2'b11, rm[0], a, (a == 8'd3) ? {7'b0, ovf_m} : rm[a], 1'b0);
         wait_frames($countones(rm[2][3:0]), 200, "rd_frames");
         while (capq.size() > 0) begin
            cap = capq.pop_front();
            chk("rd_lane_en", rm[2][cap[65:64]], 1);
            chk("rd_reply", cap[63:0], e);
         end
      end else begin
         repeat (90) @(negedge clk);
         chk("no_reply", capq.size(), 0);
         capq.delete();
      end
   endtask

   task automatic fire(output int t0);
      @(negedge clk); external_trigger = 1'b1; t0 = cyc;
      repeat (2) @(negedge clk);
      external_trigger = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_data(input logic [65:0] cap, input int t0);
      logic [63:0] p;
      p = cap[63:0];
      chk("d_lane_en", rm[2][cap[65:64]], 1);
      chk("d_type", p[1:0], 2'b01);
      chk("d_chip", p[9:2], rm[0]);
      chk("d_chan", p[15:10], 6'h3F);
      chk("d_ttype", p[49:48], 2'b10);
      chk("d_zero", {p[62:50], p[47:40]}, 0);
      chk("d_parity", $countones(p) % 2, 1);
      chk("d_ts_win", (int'(p[39:16]) >= t0) && (int'(p[39:16]) <= t0 + 3), 1);
   endtask

   task automatic trig_check();
      int t0, p0;
      p0 = dpulse;
      fire(t0);
      wait_frames($countones(rm[2][3:0]), 150, "trig_frames");
      chk("trig_latency", (last_start - t0) <= 6, 1);
      chk("trig_pulse", dpulse - p0, 1);
      while (capq.size() > 0) check_data(capq.pop_front(), t0);
   endtask

   initial begin
      int t0, p0, l0, n, k;
      int tq[10];
      logic [1:0] t;
      logic [7:0] c;
      for (int i = 0; i < 256; i++) rm[i] = 8'h00;
      rm[0] = 8'h01; rm[2] = 8'h0F;
      posi = 4'hF; external_trigger = 1'b0; reset_n = 1'b0;

      repeat (10) @(negedge clk);
      chk("rst_piso", piso, 4'hF);
      chk("rst_dmon", digital_monitor, 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      xact(2'b11, 8'h01, 8'd2, 8'h00, 0, 0);        // reply data 0F, all lanes

      // trigger while disabled: nothing at all
      p0 = dpulse; l0 = lowcnt;
      @(negedge clk); external_trigger = 1'b1;
      repeat (20) @(negedge clk); external_trigger = 1'b0;
      repeat (200) @(negedge clk);
      chk("dis_pulse", dpulse - p0, 0);
      chk("dis_piso", lowcnt - l0, 0);
      chk("dis_frames", capq.size(), 0);

      xact(2'b10, 8'h01, 8'd1, 8'h01, 0, 1);        // enable trigger via posi[1]
      trig_check();

      // chip-id / parity filtering
      xact(2'b10, 8'h02, 8'd10, 8'hAA, 0, 1);
      xact(2'b11, 8'h01, 8'd10, 8'h00, 0, 1);
      xact(2'b10, 8'hFF, 8'd10, 8'hAB, 0, 2);
      xact(2'b11, 8'h01, 8'd10, 8'h00, 0, 3);
      xact(2'b10, 8'h01, 8'd10, 8'h55, 1, 0);
      xact(2'b11, 8'hFF, 8'd10, 8'h00, 0, 0);

      // randomized config traffic
      for (int i = 0; i < 25; i++) begin
         k = $urandom_range(0, 3);
         t = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b11;
         case ($urandom_range(0, 3))
            0: c = 8'h01;
            1: c = 8'h02;
            2: c = 8'hFF;
            default: c = 8'($urandom);
         endcase
         xact(t, c, 8'($urandom_range(4, 255)), 8'($urandom), $urandom_range(0, 4) == 0,
              $urandom_range(0, 3));
      end

      // lane enable: only piso[1]
      xact(2'b10, 8'h01, 8'd2, 8'h02, 0, 1);
      l0 = lowcnt;
      trig_check();

      // overflow: one frame in flight, eight queued, the rest dropped
      p0 = dpulse;
      for (int i = 0; i < 10; i++) fire(tq[i]);
      chk("ovf_pulses", dpulse - p0, 10);
      k = 0;
      while (capq.size() < 9 && k < 1500) begin @(negedge clk); k++; end
      repeat (80) @(negedge clk);
      n = capq.size();
      chk("ovf_frame_cnt", (n >= 8) && (n <= 9), 1);
      for (int i = 0; i < n; i++) check_data(capq.pop_front(), tq[i]);
      ovf_m = 1'b1;
      xact(2'b11, 8'h01, 8'd3, 8'h00, 0, 1);        // reg3 reads 01

      // reset in the middle of an outgoing frame
      fire(t0);
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_piso", piso, 4'hF);
      chk("midrst_dmon", digital_monitor, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("midrst_frames", capq.size(), 0);
      chk("midrst_piso_idle", piso, 4'hF);

      chk("frame_stop_err", frame_err, 0);
      chk("dmon_width", dhigh, dpulse);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
